seq_divider_hs: RTL and testbench

- Parametrised iterative radix-2 integer divider with signed and unsigned modes.
- Successor to the fixed-width FSM divider. Adds:
  - valid/ready handshakes on both input and output;
  - deterministic latency;
  - divide-by-zero and signed-overflow fast paths with flags;
  - a synchronous flush input.
- Sits behind the execute-stage issue logic; one operation in flight at a time.

---
 rtl/seq_divider_hs.sv | 189 ++++++++++++++++++
 tb/tb_seq_divider_hs.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_hs.sv
// Iterative radix-2 restoring divider with valid/ready handshakes, signed/unsigned
// modes, divide-by-zero and signed-overflow fast paths, and a synchronous flush.
module seq_divider_hs #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             is_unsigned,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int               CNT_W      = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ZERO_C     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES_C     = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE_C      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MIN_C      = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LOAD_C = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_ITER = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t           state_r;
   logic             idle_r;
   logic             uns_r;
   logic [WIDTH-1:0] dvd_r;
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH-1:0] pr_r;
   logic [CNT_W-1:0] cnt_r;
   logic             neg_q_r;
   logic             neg_r_r;
   logic [WIDTH-1:0] quotient_r;
   logic [WIDTH-1:0] remainder_r;
   logic             out_valid_r;
   logic             dbz_r;
   logic             ovf_r;

   logic [WIDTH:0]   shift_s;
   logic [WIDTH:0]   trial_s;
   logic             dvd_neg_s;
   logic             dvs_neg_s;
   logic [WIDTH-1:0] dvd_mag_s;
   logic [WIDTH-1:0] dvs_mag_s;
   logic [WIDTH-1:0] q_fix_s;
   logic [WIDTH-1:0] r_fix_s;
   logic             div_zero_s;
   logic             sgn_ovf_s;

   // Datapath: one restoring step, operand magnitudes, sign fix-up and fast-path detection.
   always_comb begin
      shift_s    = {pr_r, dvd_r[WIDTH-1]};
      trial_s    = shift_s - {1'b0, dvs_r};
      dvd_neg_s  = ~uns_r & dvd_r[WIDTH-1];
      dvs_neg_s  = ~uns_r & dvs_r[WIDTH-1];
      dvd_mag_s  = dvd_neg_s ? (~dvd_r + ONE_C) : dvd_r;
      dvs_mag_s  = dvs_neg_s ? (~dvs_r + ONE_C) : dvs_r;
      q_fix_s    = neg_q_r ? (~dvd_r + ONE_C) : dvd_r;
      r_fix_s    = neg_r_r ? (~pr_r + ONE_C) : pr_r;
      div_zero_s = (dvs_r == ZERO_C);
      sgn_ovf_s  = ~uns_r & (dvd_r == MIN_C) & (dvs_r == ONES_C);
   end

   // Control FSM and all registered state; dvd_r doubles as the quotient shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         idle_r      <= 1'b1;
         uns_r       <= 1'b0;
         dvd_r       <= ZERO_C;
         dvs_r       <= ZERO_C;
         pr_r        <= ZERO_C;
         cnt_r       <= CNT_ZERO_C;
         neg_q_r     <= 1'b0;
         neg_r_r     <= 1'b0;
         quotient_r  <= ZERO_C;
         remainder_r <= ZERO_C;
         out_valid_r <= 1'b0;
         dbz_r       <= 1'b0;
         ovf_r       <= 1'b0;
      end else if (flush) begin
         state_r     <= ST_IDLE;
         idle_r      <= 1'b1;
         out_valid_r <= 1'b0;
         dbz_r       <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  uns_r   <= is_unsigned;
                  dvd_r   <= dividend;
                  dvs_r   <= divisor;
                  idle_r  <= 1'b0;
                  state_r <= ST_PREP;
               end else begin
                  idle_r  <= 1'b1;
               end
            end
            ST_PREP: begin
               if (div_zero_s) begin
                  quotient_r  <= ONES_C;
                  remainder_r <= dvd_r;
                  dbz_r       <= 1'b1;
                  state_r     <= ST_DONE;
               end else if (sgn_ovf_s) begin
                  quotient_r  <= MIN_C;
                  remainder_r <= ZERO_C;
                  ovf_r       <= 1'b1;
                  state_r     <= ST_DONE;
               end else begin
                  dvd_r   <= dvd_mag_s;
                  dvs_r   <= dvs_mag_s;
                  pr_r    <= ZERO_C;
                  cnt_r   <= CNT_LOAD_C;
                  neg_q_r <= dvd_neg_s ^ dvs_neg_s;
                  neg_r_r <= dvd_neg_s;
                  state_r <= ST_ITER;
               end
            end
            ST_ITER: begin
               // A clear borrow bit means the trial subtraction fits: keep it and emit a 1.
               if (!trial_s[WIDTH]) begin
                  pr_r  <= trial_s[WIDTH-1:0];
                  dvd_r <= {dvd_r[WIDTH-2:0], 1'b1};
               end else begin
                  pr_r  <= shift_s[WIDTH-1:0];
                  dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
               end
               cnt_r <= cnt_r - CNT_ONE_C;
               if (cnt_r == CNT_ZERO_C) begin
                  state_r <= ST_FIX;
               end else begin
                  state_r <= ST_ITER;
               end
            end
            ST_FIX: begin
               quotient_r  <= q_fix_s;
               remainder_r <= r_fix_s;
               state_r     <= ST_DONE;
            end
            ST_DONE: begin
               // out_valid rises one cycle after entry so both paths share the same tail.
               if (!out_valid_r) begin
                  out_valid_r <= 1'b1;
               end else if (out_ready) begin
                  out_valid_r <= 1'b0;
                  dbz_r       <= 1'b0;
                  ovf_r       <= 1'b0;
                  idle_r      <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               idle_r      <= 1'b1;
               out_valid_r <= 1'b0;
               dbz_r       <= 1'b0;
               ovf_r       <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = idle_r & ~flush;
   assign out_valid   = out_valid_r;
   assign quotient    = quotient_r;
   assign remainder   = remainder_r;
   assign div_by_zero = dbz_r;
   assign overflow    = ovf_r;

endmodule

// File: tb/tb_seq_divider_hs.sv
// Scoreboard bench for seq_divider_hs: a 32-bit and an 8-bit instance, checking
// results, flags, latency, hold/release, flush and asynchronous reset.
module tb_seq_divider_hs;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      logic        ovf;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;

   logic        in_valid32 = 1'b0, in_ready32, uns32 = 1'b0;
   logic [31:0] dividend32 = 32'd0, divisor32 = 32'd0;
   logic        out_valid32, out_ready32 = 1'b1;
   logic [31:0] quotient32, remainder32;
   logic        dbz32, ovf32;

   logic        in_valid8 = 1'b0, in_ready8, uns8 = 1'b0;
   logic [7:0]  dividend8 = 8'd0, divisor8 = 8'd0;
   logic        out_valid8, out_ready8 = 1'b1;
   logic [7:0]  quotient8, remainder8;
   logic        dbz8, ovf8;

   exp_t sb32_q[$];
   exp_t sb8_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   seq_divider_hs #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid32), .in_ready(in_ready32), .is_unsigned(uns32),
      .dividend(dividend32), .divisor(divisor32),
      .out_valid(out_valid32), .out_ready(out_ready32),
      .quotient(quotient32), .remainder(remainder32),
      .div_by_zero(dbz32), .overflow(ovf32)
   );

   seq_divider_hs #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .flush(1'b0),
      .in_valid(in_valid8), .in_ready(in_ready8), .is_unsigned(uns8),
      .dividend(dividend8), .divisor(divisor8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .quotient(quotient8), .remainder(remainder8),
      .div_by_zero(dbz8), .overflow(ovf8)
   );

   function automatic exp_t mk(logic [31:0] q, logic [31:0] r, logic dbz, logic ovf, int lat);
      exp_t e;
      e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.lat = lat;
      return e;
   endfunction

   // Reference model for 32-bit operations, built on the simulator's own division.
   function automatic exp_t model32(logic uns, logic [31:0] a, logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a; sb = b;
      if (b == 32'd0)                                        return mk(32'hFFFFFFFF, a, 1'b1, 1'b0, 2);
      else if (!uns && a == 32'h80000000 && b == 32'hFFFFFFFF) return mk(32'h80000000, 32'd0, 1'b0, 1'b1, 2);
      else if (uns)                                          return mk(a / b, a % b, 1'b0, 1'b0, 35);
      else                                                   return mk(sa / sb, sa % sb, 1'b0, 1'b0, 35);
   endfunction

   task automatic issue32(input logic uns, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      n_checks++;
      if (in_ready32 !== 1'b1) begin
         n_errors++;
         $display("FAIL in_ready32 before issue: got %b want 1", in_ready32);
      end
      uns32 = uns; dividend32 = a; divisor32 = b; in_valid32 = 1'b1;
      @(posedge clk);
      #1;
      in_valid32 = 1'b0;
      dividend32 = 32'hDEADBEEF; divisor32 = 32'h0; uns32 = ~uns;
   endtask

   task automatic collect32(input string name, input int hold);
      exp_t e;
      int   cyc = 0;
      do begin
         @(posedge clk); #1; cyc++;
      end while (out_valid32 !== 1'b1 && cyc < 200);
      e = sb32_q.pop_front();
      n_checks++;
      if (out_valid32 !== 1'b1) begin
         n_errors++;
         $display("FAIL %s timeout: out_valid never rose in %0d cycles", name, cyc);
         return;
      end
      n_checks++;
      if (cyc !== e.lat) begin n_errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat); end
      n_checks++;
      if (quotient32 !== e.q || remainder32 !== e.r || dbz32 !== e.dbz || ovf32 !== e.ovf) begin
         n_errors++;
         $display("FAIL %s result: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                  name, quotient32, remainder32, dbz32, ovf32, e.q, e.r, e.dbz, e.ovf);
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid32 !== 1'b1 || quotient32 !== e.q || remainder32 !== e.r || dbz32 !== e.dbz || in_ready32 !== 1'b0) begin
            n_errors++;
            $display("FAIL %s hold %0d: got v=%b q=%h r=%h dbz=%b rdy=%b want v=1 q=%h r=%h dbz=%b rdy=0",
                     name, i, out_valid32, quotient32, remainder32, dbz32, in_ready32, e.q, e.r, e.dbz);
         end
      end
      if (hold > 0) begin
         @(negedge clk);
         out_ready32 = 1'b1;
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
         n_errors++;
         $display("FAIL %s release: got out_valid=%b in_ready=%b want 0 1", name, out_valid32, in_ready32);
      end
   endtask

   task automatic issue8(input logic uns, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      uns8 = uns; dividend8 = a; divisor8 = b; in_valid8 = 1'b1;
      @(posedge clk);
      #1;
      in_valid8 = 1'b0;
      dividend8 = 8'h5A; divisor8 = 8'h00;
   endtask

   task automatic collect8(input string name);
      exp_t e;
      int   cyc = 0;
      do begin
         @(posedge clk); #1; cyc++;
      end while (out_valid8 !== 1'b1 && cyc < 100);
      e = sb8_q.pop_front();
      n_checks++;
      if (cyc !== e.lat || out_valid8 !== 1'b1) begin
         n_errors++;
         $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, cyc, out_valid8, e.lat);
      end
      n_checks++;
      if (quotient8 !== e.q[7:0] || remainder8 !== e.r[7:0] || dbz8 !== e.dbz || ovf8 !== e.ovf) begin
         n_errors++;
         $display("FAIL %s result: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                  name, quotient8, remainder8, dbz8, ovf8, e.q[7:0], e.r[7:0], e.dbz, e.ovf);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if (out_valid32 !== 1'b0 || quotient32 !== 32'd0 || remainder32 !== 32'd0 || dbz32 !== 1'b0 || ovf32 !== 1'b0) begin
         n_errors++;
         $display("FAIL reset values: got v=%b q=%h r=%h dbz=%b ovf=%b want all 0",
                  out_valid32, quotient32, remainder32, dbz32, ovf32);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready32 !== 1'b1 || in_ready8 !== 1'b1) begin
         n_errors++;
         $display("FAIL reset in_ready: got %b/%b want 1/1", in_ready32, in_ready8);
      end
   endtask

   task automatic test_unsigned_hold();
      out_ready32 = 1'b0;
      sb32_q.push_back(mk(32'd14, 32'd2, 1'b0, 1'b0, 35));
      issue32(1'b1, 32'd100, 32'd7);
      collect32("u100_7", 5);
   endtask

   task automatic test_signed();
      sb32_q.push_back(mk(32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 35));
      issue32(1'b0, 32'hFFFFFFF9, 32'd2);
      collect32("s-7_2", 0);
      sb32_q.push_back(mk(32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, 35));
      issue32(1'b0, 32'd7, 32'hFFFFFFFE);
      collect32("s7_-2", 0);
      sb32_q.push_back(mk(32'd3, 32'hFFFFFFFF, 1'b0, 1'b0, 35));
      issue32(1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE);
      collect32("s-7_-2", 0);
   endtask

   task automatic test_fast_paths();
      sb32_q.push_back(mk(32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, 2));
      issue32(1'b0, 32'd5, 32'd0);
      collect32("s5_0", 0);
      sb32_q.push_back(mk(32'h80000000, 32'd0, 1'b0, 1'b1, 2));
      issue32(1'b0, 32'h80000000, 32'hFFFFFFFF);
      collect32("smin_-1", 0);
      sb32_q.push_back(mk(32'hFFFFFFFF, 32'h12345678, 1'b1, 1'b0, 2));
      issue32(1'b1, 32'h12345678, 32'd0);
      collect32("u_div0", 0);
   endtask

   task automatic test_unsigned_edges();
      sb32_q.push_back(mk(32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 35));
      issue32(1'b1, 32'hFFFFFFFF, 32'd1);
      collect32("umax_1", 0);
      sb32_q.push_back(mk(32'd0, 32'h80000000, 1'b0, 1'b0, 35));
      issue32(1'b1, 32'h80000000, 32'hFFFFFFFF);
      collect32("umin_max", 0);
   endtask

   task automatic watch_idle(input string name);
      int seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (out_valid32 === 1'b1) seen++;
      end
      n_checks++;
      if (seen !== 0) begin n_errors++; $display("FAIL %s out_valid rose: got %0d cycles want 0", name, seen); end
   endtask

   task automatic test_flush();
      issue32(1'b1, 32'd1000, 32'd7);
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      n_checks++;
      if (in_ready32 !== 1'b0) begin n_errors++; $display("FAIL flush in_ready during flush: got %b want 0", in_ready32); end
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      n_checks++;
      if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
         n_errors++;
         $display("FAIL flush after: got out_valid=%b in_ready=%b want 0 1", out_valid32, in_ready32);
      end
      watch_idle("flush");
      sb32_q.push_back(mk(32'd3, 32'd0, 1'b0, 1'b0, 35));
      issue32(1'b0, 32'd9, 32'd3);
      collect32("flush_9_3", 0);
   endtask

   task automatic test_async_reset();
      issue32(1'b0, 32'hFFFFF000, 32'd13);
      repeat (10) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid32 !== 1'b0 || quotient32 !== 32'd0 || remainder32 !== 32'd0 || dbz32 !== 1'b0 || ovf32 !== 1'b0) begin
         n_errors++;
         $display("FAIL async reset values: got v=%b q=%h r=%h want 0 0 0", out_valid32, quotient32, remainder32);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready32 !== 1'b1) begin n_errors++; $display("FAIL async reset in_ready: got %b want 1", in_ready32); end
      watch_idle("async_rst");
      sb32_q.push_back(mk(32'd3, 32'd0, 1'b0, 1'b0, 35));
      issue32(1'b0, 32'd9, 32'd3);
      collect32("rst_9_3", 0);
   endtask

   task automatic test_random();
      logic        uns;
      logic [31:0] a, b;
      for (int i = 0; i < 8; i++) begin
         uns = 1'($urandom_range(0, 1));
         a   = $urandom;
         b   = $urandom >> $urandom_range(0, 31);
         sb32_q.push_back(model32(uns, a, b));
         issue32(uns, a, b);
         collect32("random", 0);
      end
   endtask

   task automatic test_width8();
      sb8_q.push_back(mk(32'd66, 32'd2, 1'b0, 1'b0, 11));
      issue8(1'b1, 8'd200, 8'd3);
      collect8("w8_u200_3");
      sb8_q.push_back(mk(32'hD6, 32'hFE, 1'b0, 1'b0, 11));
      issue8(1'b0, 8'h80, 8'd3);
      collect8("w8_s-128_3");
      sb8_q.push_back(mk(32'h80, 32'h00, 1'b0, 1'b1, 2));
      issue8(1'b0, 8'h80, 8'hFF);
      collect8("w8_ovf");
   endtask

   initial begin
      test_reset();
      test_unsigned_hold();
      test_signed();
      test_fast_paths();
      test_unsigned_edges();
      test_flush();
      test_async_reset();
      test_random();
      test_width8();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
